alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station feeding the single ALU. Holds dispatched ALU/branch ops, wakes operands by
//  snooping the CDB, and issues one ready op per update phase to the ALU when it is not full.
//  Sits between the instruction-queue dispatch path and the ALU; obeys the update_stat two-phase scheme.
// PARAMETERS
//  RS_SIZE      8   entry count, power of two, >= 2
//  RS_IDX_W     3   log2(RS_SIZE)
//  IQ_ADDR_W    4   width of IqAddrType (instr-queue index / operand tag)
//  CALC_CODE_W  4   width of CalcCodeType
//  WORD_W       32  width of WordType
// PORTS
//  clk                 in   1            clock
//  rst                 in   1            synchronous, active-high reset
//  rdy                 in   1            global ready; chip_enable <= rdy, registered
//  update_stat         in   1            phase: 0 = RS update/issue cycle, 1 = ALU sample cycle
//  clear_flag_in       in   1            misprediction flush
//  rs_full_out         out  1            no free entry (combinational from registered busy bits)
//  dispatch_enable_in  in   1            new op valid (honoured only in phase 0)
//  dispatch_code_in    in   CALC_CODE_W  ALU op code, 0..15
//  dispatch_lhs_ready_in / dispatch_rhs_ready_in  in 1  operand value already known
//  dispatch_lhs_in / dispatch_rhs_in        in WORD_W     operand value (valid when ready)
//  dispatch_lhs_tag_in / dispatch_rhs_tag_in  in IQ_ADDR_W  producer iq index (when not ready)
//  dispatch_pos_in_iq_in  in  IQ_ADDR_W  iq slot of this op
//  cdb_enable_in       in   1            broadcast valid
//  cdb_idx_in          in   IQ_ADDR_W    producer iq index
//  cdb_result_in       in   WORD_W       broadcast value
//  alu_full_in         in   1            ALU holds an unwritten result
//  alu_calc_enable_out out  1            issue valid to ALU
//  alu_calc_code_out   out  CALC_CODE_W  op code
//  alu_lhs_out / alu_rhs_out  out  WORD_W  operands
//  alu_pos_in_iq_out   out  IQ_ADDR_W    iq slot
// BEHAVIOUR
//  - Reset: all entries free, chip_enable=0, alu_calc_enable_out=0, all other alu_* outputs 0.
//  - chip_enable=0 (rdy low): state and outputs frozen.
//  - All state changes occur only in phase 0 (update_stat=0); phase-1 cycles hold every register.
//  - Phase 0, per entry: if cdb_enable_in and operand not ready and tag==cdb_idx_in -> value=result, ready=1.
//  - Dispatch: if dispatch_enable_in && !rs_full_out, write lowest-index free entry; each operand
//    also woken same cycle if the CDB matches its tag (bypass). If full, dispatch ignored.
//  - Issue: if !alu_full_in, pick lowest-index busy entry with both operands ready (values as held at
//    start of cycle; a CDB wake-up is issuable next phase 0). Register alu_* outputs, free entry,
//    alu_calc_enable_out=1. Else alu_calc_enable_out=0.
//  - alu_* outputs stay stable through the following phase-1 cycle (ALU samples there).
//  - alu_calc_code_out keeps last issued value while enable=0 (ALU reads it at writeback for need_cdb).
//  - Freed slot is not reusable by a dispatch in the same cycle; rs_full_out from start-of-cycle state.
//  - clear_flag_in=1 in phase 0: all entries freed, alu_calc_enable_out=0; dispatch/CDB/issue that
//    cycle discarded. Flush has priority over everything except rst.
//  - Latency: dispatch with both ready -> alu_calc_enable_out at earliest the next phase 0 (2 cycles).
// STRUCTURE
//  - Shared package (defines.v): WordType, IqAddrType, CalcCodeType, True/False, RS_SIZE.
//  - One sub-module: rs_pick (RS_SIZE-bit vector -> lowest-set index + valid), instanced twice:
//    free-slot select (on ~busy) and issue select (on busy & lhs_ready & rhs_ready).
// TESTING
//  - Reset: rst 1 cycle -> rs_full_out=0, alu_calc_enable_out=0, alu_lhs_out=0.
//  - Ready op: dispatch code 0, lhs=5, rhs=7, pos=3 both ready -> next phase 0: enable=1, code 0,
//    lhs 5, rhs 7, pos 3; entry freed; enable=0 next phase 0.
//  - Wakeup: dispatch rhs tag 9 not ready; later CDB idx 9 result 0x10 -> issue following phase 0
//    with rhs=0x10; CDB idx 8 -> no wake.
//  - Bypass: dispatch lhs tag 2 while CDB idx 2 result 0xABCD same cycle -> entry ready, issues next phase 0.
//  - Full/backpressure: 8 dispatches with alu_full_in=1 -> rs_full_out=1, 9th ignored, no issue;
//    drop alu_full_in -> entry 0 issues first, rs_full_out=0 after.
//  - Flush: 3 busy entries + pending issue, clear_flag_in=1 -> all free, enable=0, no later issues.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared types and sizes for the ALU reservation station
package alu_rs_pkg;
  localparam int RS_SIZE     = 8;
  localparam int RS_IDX_W    = 3;
  localparam int IQ_ADDR_W   = 4;
  localparam int CALC_CODE_W = 4;
  localparam int WORD_W      = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [IQ_ADDR_W-1:0]   iq_addr_t;
  typedef logic [CALC_CODE_W-1:0] calc_code_t;
  typedef logic [RS_IDX_W-1:0]    rs_idx_t;

  typedef struct packed {
    logic       busy;
    calc_code_t code;
    logic       lhs_rdy;
    logic       rhs_rdy;
    word_t      lhs;
    word_t      rhs;
    iq_addr_t   lhs_tag;
    iq_addr_t   rhs_tag;
    iq_addr_t   pos;
  } rs_entry_t;

  typedef struct packed {
    logic       en;
    calc_code_t code;
    word_t      lhs;
    word_t      rhs;
    iq_addr_t   pos;
  } alu_req_t;
endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, CDB and ALU-issue signals of the reservation station
interface alu_rs_if import alu_rs_pkg::*; ();
  logic       dispatch_enable_in;
  calc_code_t dispatch_code_in;
  logic       dispatch_lhs_ready_in;
  logic       dispatch_rhs_ready_in;
  word_t      dispatch_lhs_in;
  word_t      dispatch_rhs_in;
  iq_addr_t   dispatch_lhs_tag_in;
  iq_addr_t   dispatch_rhs_tag_in;
  iq_addr_t   dispatch_pos_in_iq_in;
  logic       cdb_enable_in;
  iq_addr_t   cdb_idx_in;
  word_t      cdb_result_in;
  logic       alu_full_in;
  logic       rs_full_out;
  logic       alu_calc_enable_out;
  calc_code_t alu_calc_code_out;
  word_t      alu_lhs_out;
  word_t      alu_rhs_out;
  iq_addr_t   alu_pos_in_iq_out;

  modport slave (
    input  dispatch_enable_in, dispatch_code_in, dispatch_lhs_ready_in, dispatch_rhs_ready_in,
    input  dispatch_lhs_in, dispatch_rhs_in, dispatch_lhs_tag_in, dispatch_rhs_tag_in,
    input  dispatch_pos_in_iq_in, cdb_enable_in, cdb_idx_in, cdb_result_in, alu_full_in,
    output rs_full_out, alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out,
    output alu_pos_in_iq_out
  );

  modport master (
    output dispatch_enable_in, dispatch_code_in, dispatch_lhs_ready_in, dispatch_rhs_ready_in,
    output dispatch_lhs_in, dispatch_rhs_in, dispatch_lhs_tag_in, dispatch_rhs_tag_in,
    output dispatch_pos_in_iq_in, cdb_enable_in, cdb_idx_in, cdb_result_in, alu_full_in,
    input  rs_full_out, alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out,
    input  alu_pos_in_iq_out
  );
endinterface

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - lowest-set-bit index selector
module alu_rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: holds ops, wakes operands off the CDB, issues one per phase 0
module alu_rs import alu_rs_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     update_stat,
  input  logic     clear_flag_in,
  alu_rs_if.slave  bus
);
  rs_entry_t            ent_q [RS_SIZE];
  rs_entry_t            ent_d [RS_SIZE];
  alu_req_t             out_q;
  alu_req_t             out_d;
  logic                 chip_enable_q;
  logic [RS_SIZE-1:0]   busy_vec;
  logic [RS_SIZE-1:0]   ready_vec;
  rs_idx_t              free_idx;
  rs_idx_t              iss_idx;
  logic                 free_vld;
  logic                 iss_vld;
  logic                 update;
  logic                 lhs_hit;
  logic                 rhs_hit;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].lhs_rdy & ent_q[i].rhs_rdy;
    end
  end

  alu_rs_pick #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_pick (
    .req_i   (~busy_vec),
    .idx_o   (free_idx),
    .valid_o (free_vld)
  );

  alu_rs_pick #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_pick (
    .req_i   (ready_vec),
    .idx_o   (iss_idx),
    .valid_o (iss_vld)
  );

  assign update  = chip_enable_q & ~update_stat;
  assign lhs_hit = bus.cdb_enable_in & (bus.cdb_idx_in == bus.dispatch_lhs_tag_in);
  assign rhs_hit = bus.cdb_enable_in & (bus.cdb_idx_in == bus.dispatch_rhs_tag_in);

  always_comb begin
    ent_d = ent_q;
    out_d = out_q;
    if (update) begin
      out_d.en = FALSE;
      if (clear_flag_in) begin
        for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = FALSE;
      end else begin
        // Issue reads start-of-cycle operands; a same-cycle wake-up waits for the next phase 0.
        if (!bus.alu_full_in && iss_vld) begin
          out_d.en   = TRUE;
          out_d.code = ent_q[iss_idx].code;
          out_d.lhs  = ent_q[iss_idx].lhs;
          out_d.rhs  = ent_q[iss_idx].rhs;
          out_d.pos  = ent_q[iss_idx].pos;
          ent_d[iss_idx].busy = FALSE;
        end
        if (bus.cdb_enable_in) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (!ent_q[i].lhs_rdy && ent_q[i].lhs_tag == bus.cdb_idx_in) begin
              ent_d[i].lhs     = bus.cdb_result_in;
              ent_d[i].lhs_rdy = TRUE;
            end
            if (!ent_q[i].rhs_rdy && ent_q[i].rhs_tag == bus.cdb_idx_in) begin
              ent_d[i].rhs     = bus.cdb_result_in;
              ent_d[i].rhs_rdy = TRUE;
            end
          end
        end
        // free_idx comes from start-of-cycle busy bits, so the slot just issued is never reused here.
        if (bus.dispatch_enable_in && free_vld) begin
          ent_d[free_idx].busy    = TRUE;
          ent_d[free_idx].code    = bus.dispatch_code_in;
          ent_d[free_idx].lhs_tag = bus.dispatch_lhs_tag_in;
          ent_d[free_idx].rhs_tag = bus.dispatch_rhs_tag_in;
          ent_d[free_idx].pos     = bus.dispatch_pos_in_iq_in;
          ent_d[free_idx].lhs_rdy = bus.dispatch_lhs_ready_in | lhs_hit;
          ent_d[free_idx].rhs_rdy = bus.dispatch_rhs_ready_in | rhs_hit;
          ent_d[free_idx].lhs     = (!bus.dispatch_lhs_ready_in && lhs_hit) ?
                                    bus.cdb_result_in : bus.dispatch_lhs_in;
          ent_d[free_idx].rhs     = (!bus.dispatch_rhs_ready_in && rhs_hit) ?
                                    bus.cdb_result_in : bus.dispatch_rhs_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chip_enable_q <= 1'b0;
      out_q         <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
    end else begin
      chip_enable_q <= rdy;
      out_q         <= out_d;
      ent_q         <= ent_d;
    end
  end

  assign bus.rs_full_out         = ~free_vld;
  assign bus.alu_calc_enable_out = out_q.en;
  assign bus.alu_calc_code_out   = out_q.code;
  assign bus.alu_lhs_out         = out_q.lhs;
  assign bus.alu_rhs_out         = out_q.rhs;
  assign bus.alu_pos_in_iq_out   = out_q.pos;
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs with a slot-array reference model
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, update_stat, clear_flag_in;
  alu_rs_if bus();

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .update_stat(update_stat),
    .clear_flag_in(clear_flag_in), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [3:0]  code;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  pos;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  exp_t sb[$];

  bit          m_busy [8];
  bit          m_lr [8];
  bit          m_rr [8];
  logic [31:0] m_l [8];
  logic [31:0] m_r [8];
  logic [3:0]  m_code [8];
  logic [3:0]  m_lt [8];
  logic [3:0]  m_rt [8];
  logic [3:0]  m_pos [8];
  exp_t        m_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit model_full();
    int cnt = 0;
    for (int i = 0; i < 8; i++) if (m_busy[i]) cnt++;
    return cnt == 8;
  endfunction

  task automatic model_step(input bit de, input logic [3:0] c, input bit lr, input logic [31:0] l,
                            input logic [3:0] lt, input bit rr, input logic [31:0] r,
                            input logic [3:0] rt, input logic [3:0] pos, input bit ce,
                            input logic [3:0] ci, input logic [31:0] cr, input bit af, input bit clr);
    int fi = -1;
    int ii = -1;
    for (int i = 0; i < 8; i++) begin
      if (!m_busy[i] && fi < 0) fi = i;
      if (m_busy[i] && m_lr[i] && m_rr[i] && ii < 0) ii = i;
    end
    m_last.en = 1'b0;
    if (clr) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
    end else begin
      if (!af && ii >= 0) begin
        m_last.en   = 1'b1;
        m_last.code = m_code[ii];
        m_last.lhs  = m_l[ii];
        m_last.rhs  = m_r[ii];
        m_last.pos  = m_pos[ii];
        m_busy[ii]  = 0;
      end
      if (ce) begin
        for (int i = 0; i < 8; i++) begin
          if (!m_lr[i] && m_lt[i] == ci) begin m_l[i] = cr; m_lr[i] = 1; end
          if (!m_rr[i] && m_rt[i] == ci) begin m_r[i] = cr; m_rr[i] = 1; end
        end
      end
      if (de && fi >= 0) begin
        m_busy[fi] = 1; m_code[fi] = c; m_pos[fi] = pos; m_lt[fi] = lt; m_rt[fi] = rt;
        m_lr[fi] = lr || (ce && lt == ci);
        m_rr[fi] = rr || (ce && rt == ci);
        m_l[fi]  = (!lr && ce && lt == ci) ? cr : l;
        m_r[fi]  = (!rr && ce && rt == ci) ? cr : r;
      end
    end
    sb.push_back(m_last);
  endtask

  // One phase-0 cycle carrying the stimulus, then one phase-1 cycle with it withdrawn.
  task automatic step(input bit de, input logic [3:0] c, input bit lr, input logic [31:0] l,
                      input logic [3:0] lt, input bit rr, input logic [31:0] r,
                      input logic [3:0] rt, input logic [3:0] pos, input bit ce,
                      input logic [3:0] ci, input logic [31:0] cr, input bit af, input bit clr);
    @(negedge clk);
    update_stat = 1'b0;
    clear_flag_in = clr;
    bus.dispatch_enable_in = de;    bus.dispatch_code_in = c;
    bus.dispatch_lhs_ready_in = lr; bus.dispatch_lhs_in = l; bus.dispatch_lhs_tag_in = lt;
    bus.dispatch_rhs_ready_in = rr; bus.dispatch_rhs_in = r; bus.dispatch_rhs_tag_in = rt;
    bus.dispatch_pos_in_iq_in = pos;
    bus.cdb_enable_in = ce; bus.cdb_idx_in = ci; bus.cdb_result_in = cr;
    bus.alu_full_in = af;
    #1;
    check("rs_full", {63'd0, bus.rs_full_out}, {63'd0, model_full()});
    model_step(de, c, lr, l, lt, rr, r, rt, pos, ce, ci, cr, af, clr);
    @(negedge clk);
    update_stat = 1'b1;
    clear_flag_in = 1'b0;
    bus.dispatch_enable_in = 1'b0;
    bus.cdb_enable_in = 1'b0;
  endtask

  task automatic idle(input bit af);
    step(0, 4'd0, 0, 32'd0, 4'd0, 0, 32'd0, 4'd0, 4'd0, 0, 4'd0, 32'd0, af, 0);
  endtask

  logic mon_phase;
  exp_t mon_exp;
  exp_t mon_act;
  always @(posedge clk) begin
    mon_phase = update_stat;
    #1;
    if (mon_on && !mon_phase) begin
      mon_act = {bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                 bus.alu_rhs_out, bus.alu_pos_in_iq_out};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL issue: output with no expectation queued, got %0h", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL issue: got en=%0d code=%0h lhs=%0h rhs=%0h pos=%0h required en=%0d code=%0h lhs=%0h rhs=%0h pos=%0h",
                   mon_act.en, mon_act.code, mon_act.lhs, mon_act.rhs, mon_act.pos,
                   mon_exp.en, mon_exp.code, mon_exp.lhs, mon_exp.rhs, mon_exp.pos);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 0; m_lr[i] = 0; m_rr[i] = 0; m_l[i] = '0; m_r[i] = '0;
      m_code[i] = '0; m_lt[i] = '0; m_rt[i] = '0; m_pos[i] = '0;
    end
    rst = 1'b1; rdy = 1'b1; update_stat = 1'b1; clear_flag_in = 1'b0;
    bus.dispatch_enable_in = 0; bus.dispatch_code_in = 0;
    bus.dispatch_lhs_ready_in = 0; bus.dispatch_rhs_ready_in = 0;
    bus.dispatch_lhs_in = 0; bus.dispatch_rhs_in = 0;
    bus.dispatch_lhs_tag_in = 0; bus.dispatch_rhs_tag_in = 0; bus.dispatch_pos_in_iq_in = 0;
    bus.cdb_enable_in = 0; bus.cdb_idx_in = 0; bus.cdb_result_in = 0; bus.alu_full_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset rs_full", {63'd0, bus.rs_full_out}, 64'd0);
    check("reset enable", {63'd0, bus.alu_calc_enable_out}, 64'd0);
    check("reset lhs", {32'd0, bus.alu_lhs_out}, 64'd0);
    mon_on = 1'b1;

    // ready op
    step(1, 4'd0, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3, 0, 4'd0, 32'd0, 0, 0);
    idle(0); idle(0);

    // wakeup via CDB, non-matching broadcast first
    step(1, 4'd2, 1, 32'd1, 4'd0, 0, 32'd0, 4'd9, 4'd5, 0, 4'd0, 32'd0, 0, 0);
    step(0, 4'd0, 0, 32'd0, 4'd0, 0, 32'd0, 4'd0, 4'd0, 1, 4'd8, 32'h55, 0, 0);
    step(0, 4'd0, 0, 32'd0, 4'd0, 0, 32'd0, 4'd0, 4'd0, 1, 4'd9, 32'h10, 0, 0);
    idle(0); idle(0);

    // bypass on the dispatch cycle
    step(1, 4'd3, 0, 32'd0, 4'd2, 1, 32'd9, 4'd0, 4'd6, 1, 4'd2, 32'hABCD, 0, 0);
    idle(0); idle(0);

    // fill under backpressure, ninth dispatch dropped, then drain
    for (int i = 0; i < 9; i++)
      step(1, 4'(i), 1, 32'(100 + i), 4'd0, 1, 32'(200 + i), 4'd0, 4'(i), 0, 4'd0, 32'd0, 1, 0);
    for (int i = 0; i < 10; i++) idle(0);

    // flush with pending issue; same-cycle dispatch and CDB discarded
    for (int i = 0; i < 3; i++)
      step(1, 4'(i + 5), 1, 32'(i), 4'd0, 1, 32'(i + 1), 4'd0, 4'(i + 8), 0, 4'd0, 32'd0, 1, 0);
    step(1, 4'd7, 1, 32'd77, 4'd0, 1, 32'd78, 4'd0, 4'd1, 1, 4'd0, 32'd1, 0, 1);
    for (int i = 0; i < 3; i++) idle(0);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1), $urandom, 4'($urandom),
           $urandom_range(0, 1), $urandom, 4'($urandom), 4'($urandom),
           $urandom_range(0, 1), 4'($urandom), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    for (int i = 0; i < 10; i++) idle(0);

    @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
